// File: rtl/bsg_fifo_1r1w_flow_tracked.sv
// bsg_fifo_1r1w_flow_tracked: 1R1W FIFO (valid/ready in, valid/yumi out) with registered count_o.
// Rev 1.0
`default_nettype none

module bsg_fifo_1r1w_flow_tracked #(
  parameter int width_p = 8,
  parameter int els_p   = 64,
  localparam int count_width_lp = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [width_p-1:0]        data_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  input  logic                      yumi_i,
  output logic [count_width_lp-1:0] count_o
);

  localparam int ptr_width_lp = $clog2(els_p);
  localparam logic [ptr_width_lp-1:0]   last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [count_width_lp-1:0] full_cnt_lp = count_width_lp'(els_p);

  logic [width_p-1:0]        mem [els_p];
  logic [ptr_width_lp-1:0]   wptr, rptr;
  logic [count_width_lp-1:0] count;
  logic                      full, empty, enq, deq;

  assign full    = (count == full_cnt_lp);
  assign empty   = (count == '0);
  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign count_o = count;
  assign data_o  = mem[rptr];

  // A yumi against an empty FIFO is a protocol error and must not move state.
  assign enq = v_i & ~full;
  assign deq = yumi_i & ~empty;

  // Explicit compare keeps wrap correct for non-power-of-two depths.
  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= next_ptr(wptr);
      if (deq) rptr <= next_ptr(rptr);
      case ({enq, deq})
        2'b10:   count <= count + count_width_lp'(1);
        2'b01:   count <= count - count_width_lp'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq && !reset_i) mem[wptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && empty))
        else $error("bsg_fifo_1r1w_flow_tracked: yumi_i asserted while empty");
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bsg_fifo_1r1w_flow_tracked.sv
// tb_bsg_fifo_1r1w_flow_tracked: directed checks on a depth-4 instance and a model-checked depth-5 instance.
`default_nettype none

module tb_bsg_fifo_1r1w_flow_tracked;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // depth 4, width 8
  logic       v_a = 1'b0, yumi_a = 1'b0, ready_a, vo_a;
  logic [7:0] di_a = '0, do_a;
  logic [2:0] cnt_a;

  // depth 5, width 16
  logic        v_b = 1'b0, yumi_b = 1'b0, ready_b, vo_b;
  logic [15:0] di_b = '0, do_b;
  logic [2:0]  cnt_b;

  bsg_fifo_1r1w_flow_tracked #(.width_p(8), .els_p(4)) dut_a (
    .clk_i(clk), .reset_i(rst), .v_i(v_a), .data_i(di_a), .ready_o(ready_a),
    .v_o(vo_a), .data_o(do_a), .yumi_i(yumi_a), .count_o(cnt_a)
  );

  bsg_fifo_1r1w_flow_tracked #(.width_p(16), .els_p(5)) dut_b (
    .clk_i(clk), .reset_i(rst), .v_i(v_b), .data_i(di_b), .ready_o(ready_b),
    .v_o(vo_b), .data_o(do_b), .yumi_i(yumi_b), .count_o(cnt_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] q[$];
    logic        enq_m, deq_m;

    // reset then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("idle_count", 32'(cnt_a), 32'd0);
      check("idle_v", 32'(vo_a), 32'd0);
      check("idle_ready", 32'(ready_a), 32'd1);
      tick();
    end

    // fill with A0..A3
    for (int i = 0; i < 4; i++) begin
      v_a = 1'b1; di_a = 8'hA0 + 8'(i);
      tick();
      check("fill_count", 32'(cnt_a), 32'(i + 1));
    end
    check("full_ready", 32'(ready_a), 32'd0);
    check("full_v", 32'(vo_a), 32'd1);
    di_a = 8'hA4;
    tick();
    v_a = 1'b0;
    check("full_reject_count", 32'(cnt_a), 32'd4);
    check("full_reject_head", 32'(do_a), 32'hA0);

    // drain in order
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 32'(do_a), 32'(8'hA0 + 8'(i)));
      yumi_a = 1'b1;
      tick();
      check("drain_count", 32'(cnt_a), 32'(3 - i));
      check("drain_ready", 32'(ready_a), 32'd1);
    end
    yumi_a = 1'b0;
    check("drain_empty_v", 32'(vo_a), 32'd0);

    // simultaneous enq/deq at count=2, wrapping pointers
    for (int i = 0; i < 2; i++) begin
      v_a = 1'b1; di_a = 8'hB0 + 8'(i);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      check("sim_head", 32'(do_a), 32'(8'hB0 + 8'(i)));
      v_a = 1'b1; di_a = 8'hB2 + 8'(i); yumi_a = 1'b1;
      tick();
      check("sim_count", 32'(cnt_a), 32'd2);
    end
    v_a = 1'b0;
    check("sim_tail0", 32'(do_a), 32'hB6);
    yumi_a = 1'b1;
    tick();
    check("sim_tail1", 32'(do_a), 32'hB7);
    tick();
    yumi_a = 1'b0;
    check("sim_drained", 32'(cnt_a), 32'd0);

    // yumi in the full cycle: the offered word is not taken
    for (int i = 0; i < 4; i++) begin
      v_a = 1'b1; di_a = 8'hC0 + 8'(i);
      tick();
    end
    di_a = 8'hC4; yumi_a = 1'b1;
    tick();
    yumi_a = 1'b0;
    check("fy_count", 32'(cnt_a), 32'd3);
    check("fy_ready", 32'(ready_a), 32'd1);
    check("fy_head", 32'(do_a), 32'hC1);
    di_a = 8'hC5;
    tick();
    v_a = 1'b0;
    check("fy_refill", 32'(cnt_a), 32'd4);
    check("fy_refill_ready", 32'(ready_a), 32'd0);
    begin
      logic [7:0] exp_seq [4];
      exp_seq[0] = 8'hC1; exp_seq[1] = 8'hC2; exp_seq[2] = 8'hC3; exp_seq[3] = 8'hC5;
      for (int i = 0; i < 4; i++) begin
        check("fy_drain", 32'(do_a), 32'(exp_seq[i]));
        yumi_a = 1'b1;
        tick();
      end
      yumi_a = 1'b0;
    end
    check("fy_empty", 32'(cnt_a), 32'd0);

    // reset mid-operation with enq and yumi both presented
    for (int i = 0; i < 3; i++) begin
      v_a = 1'b1; di_a = 8'hD0 + 8'(i);
      tick();
    end
    check("pre_reset_count", 32'(cnt_a), 32'd3);
    rst = 1'b1; di_a = 8'hEE; yumi_a = 1'b1;
    tick();
    rst = 1'b0; v_a = 1'b0; yumi_a = 1'b0;
    check("rst_count", 32'(cnt_a), 32'd0);
    check("rst_v", 32'(vo_a), 32'd0);
    check("rst_ready", 32'(ready_a), 32'd1);
    v_a = 1'b1; di_a = 8'h55;
    tick();
    v_a = 1'b0;
    check("post_rst_v", 32'(vo_a), 32'd1);
    check("post_rst_data", 32'(do_a), 32'h55);
    check("post_rst_count", 32'(cnt_a), 32'd1);

    // depth 5: random traffic against a queue model
    for (int i = 0; i < 1000; i++) begin
      check("rnd_count", 32'(cnt_b), 32'(q.size()));
      check("rnd_v", 32'(vo_b), 32'(q.size() != 0));
      check("rnd_ready", 32'(ready_b), 32'(q.size() != 5));
      if (q.size() != 0) check("rnd_data", 32'(do_b), 32'(q[0]));
      v_b    = ($urandom_range(0, 99) < 55);
      di_b   = 16'($urandom);
      yumi_b = (q.size() != 0) && ($urandom_range(0, 99) < 50);
      enq_m  = v_b && (q.size() < 5);
      deq_m  = yumi_b;
      tick();
      if (deq_m) void'(q.pop_front());
      if (enq_m) q.push_back(di_b);
    end
    v_b = 1'b0; yumi_b = 1'b0;
    check("rnd_final_count", 32'(cnt_b), 32'(q.size()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
